// File: rtl/gpio_bank.sv
// gpio_bank: GPIO peripheral on the ic0 data bus. It holds NUM_PORTS ports of DW bidirectional pins.
//
// Each port has these registers, DW bits each, at byte offsets inside its 32-byte slot:
//   0x00 DIR      R/W, 1 = pin is an output
//   0x04 OUT      R/W, output value
//   0x08 IN       RO,  synchronised pin value
//   0x0C EDGE     W1C, captured edges
//   0x10 RISE_EN  R/W, enables rising-edge capture
//   0x14 FALL_EN  R/W, enables falling-edge capture
//   0x18 IRQ_MASK R/W, present only when GPIO_BANK_IRQ_EN is defined
//
// Optional feature: define the macro GPIO_BANK_IRQ_EN to add the IRQ_MASK registers and the
// gpio_irq output. Without the macro, offset 0x18 reads 0 and ignores writes, and gpio_irq is
// not a port.
//
// Ports:
//   clk                       clock; all logic acts on the rising edge
//   c_sys_rst                 synchronous active-high reset
//   gpio_io                   pins; port p uses [p*DW +: DW]
//   ic0_c_axi_mst_wr_valid    write strobe
//   ic0_axi_mst_wr_addr       write byte address
//   ic0_axi_mst_wr_data       write data
//   ic0_c_axi_mst_rd_valid    read strobe
//   ic0_axi_mst_rd_addr       read byte address
//   ic0_c_axi_slv_rd_ready_n  read response valid, one cycle after the strobe
//   ic0_axi_slv_rd_data_n     read data; zero whenever ready is low
//   gpio_irq                  level interrupt (GPIO_BANK_IRQ_EN only)
module gpio_bank #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DW        = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic                    clk,
  input  logic                    c_sys_rst,
  inout  wire  [NUM_PORTS*DW-1:0] gpio_io,
  input  logic                    ic0_c_axi_mst_wr_valid,
  input  logic [31:0]             ic0_axi_mst_wr_addr,
  input  logic [31:0]             ic0_axi_mst_wr_data,
  input  logic                    ic0_c_axi_mst_rd_valid,
  input  logic [31:0]             ic0_axi_mst_rd_addr,
  output logic                    ic0_c_axi_slv_rd_ready_n,
  output logic [31:0]             ic0_axi_slv_rd_data_n
`ifdef GPIO_BANK_IRQ_EN
  ,
  output logic                    gpio_irq
`endif
);

  // Register selects, taken from address bits [4:2].
  localparam logic [2:0] OffDir  = 3'd0;
  localparam logic [2:0] OffOut  = 3'd1;
  localparam logic [2:0] OffIn   = 3'd2;
  localparam logic [2:0] OffEdge = 3'd3;
  localparam logic [2:0] OffRise = 3'd4;
  localparam logic [2:0] OffFall = 3'd5;
`ifdef GPIO_BANK_IRQ_EN
  localparam logic [2:0] OffMask = 3'd6;
`endif

  logic [DW-1:0] r_dir     [NUM_PORTS];
  logic [DW-1:0] r_out     [NUM_PORTS];
  logic [DW-1:0] r_edge    [NUM_PORTS];
  logic [DW-1:0] r_rise_en [NUM_PORTS];
  logic [DW-1:0] r_fall_en [NUM_PORTS];
  logic [DW-1:0] r_s1      [NUM_PORTS];
  logic [DW-1:0] r_s2      [NUM_PORTS];
  logic [DW-1:0] r_s3      [NUM_PORTS];
`ifdef GPIO_BANK_IRQ_EN
  logic [DW-1:0] r_irq_mask[NUM_PORTS];
`endif

  logic [DW-1:0] w_edge_set[NUM_PORTS];
  logic [DW-1:0] w_edge_clr[NUM_PORTS];
  logic [DW-1:0] w_edge_d  [NUM_PORTS];

  logic          r_rd_ready;
  logic [31:0]   r_rd_data;

  logic          w_wr_en;
  logic          w_rd_hit;
  logic [2:0]    w_wr_port;
  logic [2:0]    w_wr_off;
  logic [2:0]    w_rd_port;
  logic [2:0]    w_rd_off;
  logic [DW-1:0] w_wr_val;
  logic [31:0]   w_rd_word;

  // Byte-lane bits and the upper write-data bits do not take part in decode or storage.
  logic unused_bits;
  assign unused_bits = ^{ic0_axi_mst_wr_addr[1:0], ic0_axi_mst_rd_addr[1:0], ic0_axi_mst_wr_data};

  // A port index beyond NUM_PORTS matches no loop iteration below. Such a write is dropped,
  // and such a read returns zero but is still acknowledged.
  assign w_wr_en   = ic0_c_axi_mst_wr_valid &&
                     (ic0_axi_mst_wr_addr[31:8] == BASE_ADDR[31:8]);
  assign w_wr_port = ic0_axi_mst_wr_addr[7:5];
  assign w_wr_off  = ic0_axi_mst_wr_addr[4:2];
  assign w_wr_val  = ic0_axi_mst_wr_data[DW-1:0];

  assign w_rd_hit  = ic0_c_axi_mst_rd_valid &&
                     (ic0_axi_mst_rd_addr[31:8] == BASE_ADDR[31:8]);
  assign w_rd_port = ic0_axi_mst_rd_addr[7:5];
  assign w_rd_off  = ic0_axi_mst_rd_addr[4:2];

  // The set term is ORed in after the clear term, so a new edge wins over a W1C in the
  // same cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_edge_clr[p] = '0;
      if (w_wr_en && (w_wr_port == 3'(p)) && (w_wr_off == OffEdge)) begin
        w_edge_clr[p] = w_wr_val;
      end
      w_edge_set[p] = (r_s2[p] & ~r_s3[p] & r_rise_en[p]) |
                      (~r_s2[p] & r_s3[p] & r_fall_en[p]);
      w_edge_d[p]   = (r_edge[p] & ~w_edge_clr[p]) | w_edge_set[p];
    end
  end

  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_dir[p]     <= '0;
        r_out[p]     <= '0;
        r_edge[p]    <= '0;
        r_rise_en[p] <= '0;
        r_fall_en[p] <= '0;
        r_s1[p]      <= '0;
        r_s2[p]      <= '0;
        r_s3[p]      <= '0;
`ifdef GPIO_BANK_IRQ_EN
        r_irq_mask[p] <= '0;
`endif
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_s1[p]   <= gpio_io[p*DW +: DW];
        r_s2[p]   <= r_s1[p];
        r_s3[p]   <= r_s2[p];
        r_edge[p] <= w_edge_d[p];
        if (w_wr_en && (w_wr_port == 3'(p))) begin
          case (w_wr_off)
            OffDir:  r_dir[p]     <= w_wr_val;
            OffOut:  r_out[p]     <= w_wr_val;
            OffRise: r_rise_en[p] <= w_wr_val;
            OffFall: r_fall_en[p] <= w_wr_val;
`ifdef GPIO_BANK_IRQ_EN
            OffMask: r_irq_mask[p] <= w_wr_val;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // The read mux uses the current register values, so a read that coincides with a write
  // returns the value from before the write.
  always_comb begin
    w_rd_word = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_rd_port == 3'(p)) begin
        case (w_rd_off)
          OffDir:  w_rd_word[DW-1:0] = r_dir[p];
          OffOut:  w_rd_word[DW-1:0] = r_out[p];
          OffIn:   w_rd_word[DW-1:0] = r_s2[p];
          OffEdge: w_rd_word[DW-1:0] = r_edge[p];
          OffRise: w_rd_word[DW-1:0] = r_rise_en[p];
          OffFall: w_rd_word[DW-1:0] = r_fall_en[p];
`ifdef GPIO_BANK_IRQ_EN
          OffMask: w_rd_word[DW-1:0] = r_irq_mask[p];
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (c_sys_rst) begin
      r_rd_ready <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_ready <= w_rd_hit;
      r_rd_data  <= w_rd_hit ? w_rd_word : '0;
    end
  end

  assign ic0_c_axi_slv_rd_ready_n = r_rd_ready;
  assign ic0_axi_slv_rd_data_n    = r_rd_data;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    for (genvar gi = 0; gi < DW; gi++) begin : g_pin
      assign gpio_io[gp*DW + gi] = r_dir[gp][gi] ? r_out[gp][gi] : 1'bz;
    end
  end

`ifdef GPIO_BANK_IRQ_EN
  always_comb begin
    gpio_irq = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      gpio_irq = gpio_irq | (|(r_edge[p] & r_irq_mask[p]));
    end
  end
`endif

endmodule
